xmm_writeback_arbiter: RTL and testbench

Shares the single XMM register-file write port between the three result producers: the ALU conversion path, the memory load path and the FPU. Each cycle the block selects at most one requester with a fixed-priority scheme and bounded anti-starvation aging. It drives the 3-bit write-source select of the XMM write-data mux, together with the write enable and destination address. It also keeps a per-register pending-write scoreboard that issue logic uses to stall on RAW hazards against in-flight XMM writes.

---
 rtl/xmm_writeback_arbiter.sv | 146 ++++++++++++++
 tb/tb_xmm_writeback_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmm_writeback_arbiter.sv
// XMM register-file write-port arbiter: fixed priority FPU > MEM > ALU with aging boost for
// MEM/ALU, write-source select generation and a per-register pending-write scoreboard.
module xmm_writeback_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      alu_valid,
  input  logic [1:0]                alu_kind,
  input  logic [ADDR_WIDTH-1:0]     alu_addr,
  output logic                      alu_ready,

  input  logic                      mem_valid,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      mem_ready,

  input  logic                      fpu_valid,
  input  logic [ADDR_WIDTH-1:0]     fpu_addr,
  output logic                      fpu_ready,

  input  logic                      issue_en,
  input  logic [ADDR_WIDTH-1:0]     issue_addr,

  output logic                      wb_en,
  output logic [ADDR_WIDTH-1:0]     wb_addr,
  output logic [2:0]                wb_src,
  output logic [(2**ADDR_WIDTH)-1:0] xmm_busy,
  output logic                      overlap_err
);

  localparam int unsigned NREG  = 2**ADDR_WIDTH;
  localparam logic [3:0]  Limit = 4'(STARVE_LIMIT);

  localparam logic [2:0] SrcNone = 3'b000;
  localparam logic [2:0] SrcMem  = 3'b100;
  localparam logic [2:0] SrcFpu  = 3'b110;
  localparam logic [2:0] SrcFp32 = 3'b010;

  logic [3:0]      mem_age_q, mem_age_d;
  logic [3:0]      alu_age_q, alu_age_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            overlap_q, overlap_d;

  logic mem_boost, alu_boost;
  logic grant_fpu, grant_mem, grant_alu;

  // Arbitration; nothing is accepted while reset is held.
  always_comb begin
    mem_boost = mem_valid && (mem_age_q == Limit);
    alu_boost = alu_valid && (alu_age_q == Limit);
    grant_fpu = 1'b0;
    grant_mem = 1'b0;
    grant_alu = 1'b0;
    if (reset) begin
      grant_fpu = 1'b0;
    end else if (mem_boost) begin
      grant_mem = 1'b1;
    end else if (alu_boost) begin
      grant_alu = 1'b1;
    end else if (fpu_valid) begin
      grant_fpu = 1'b1;
    end else if (mem_valid) begin
      grant_mem = 1'b1;
    end else if (alu_valid) begin
      grant_alu = 1'b1;
    end
  end

  assign fpu_ready = grant_fpu;
  assign mem_ready = grant_mem;
  assign alu_ready = grant_alu;
  assign wb_en     = grant_fpu | grant_mem | grant_alu;

  always_comb begin
    wb_addr = '0;
    wb_src  = SrcNone;
    unique case ({grant_fpu, grant_mem, grant_alu})
      3'b100: begin
        wb_addr = fpu_addr;
        wb_src  = SrcFpu;
      end
      3'b010: begin
        wb_addr = mem_addr;
        wb_src  = SrcMem;
      end
      3'b001: begin
        wb_addr = alu_addr;
        // Illegal kind 2'b11 is folded onto the fp32 source.
        wb_src  = (alu_kind == 2'b11) ? SrcFp32 : {1'b0, alu_kind};
      end
      default: begin
        wb_addr = '0;
        wb_src  = SrcNone;
      end
    endcase
  end

  // Age counters: count losing cycles while valid, saturating at the limit.
  always_comb begin
    mem_age_d = mem_age_q;
    if (!mem_valid || grant_mem) begin
      mem_age_d = 4'd0;
    end else if (mem_age_q < Limit) begin
      mem_age_d = mem_age_q + 4'd1;
    end

    alu_age_d = alu_age_q;
    if (!alu_valid || grant_alu) begin
      alu_age_d = 4'd0;
    end else if (alu_age_q < Limit) begin
      alu_age_d = alu_age_q + 4'd1;
    end
  end

  // Scoreboard: a new issue outranks a same-cycle writeback to the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (issue_en) begin
      busy_d[issue_addr] = 1'b1;
    end
    overlap_d = overlap_q | (issue_en & busy_q[issue_addr]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_age_q <= 4'd0;
      alu_age_q <= 4'd0;
      busy_q    <= '0;
      overlap_q <= 1'b0;
    end else begin
      mem_age_q <= mem_age_d;
      alu_age_q <= alu_age_d;
      busy_q    <= busy_d;
      overlap_q <= overlap_d;
    end
  end

  assign xmm_busy    = busy_q;
  assign overlap_err = overlap_q;

endmodule

// File: tb/tb_xmm_writeback_arbiter.sv
// Directed and randomized bench for xmm_writeback_arbiter, checked against a behavioural model
// of the arbitration rules, wait counts and pending-write scoreboard.
module tb_xmm_writeback_arbiter;

  localparam int AW    = 5;
  localparam int NREG  = 2**AW;
  localparam int LIMIT = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, mem_valid, fpu_valid, issue_en;
  logic [1:0]      alu_kind;
  logic [AW-1:0]   alu_addr, mem_addr, fpu_addr, issue_addr;
  logic            alu_ready, mem_ready, fpu_ready;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [2:0]      wb_src;
  logic [NREG-1:0] xmm_busy;
  logic            overlap_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            m_mem_wait, m_alu_wait;
  bit [NREG-1:0] m_busy;
  bit            m_ovf;
  int            last_g;

  always #5 clk = ~clk;

  xmm_writeback_arbiter #(
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_kind   (alu_kind),
    .alu_addr   (alu_addr),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .fpu_valid  (fpu_valid),
    .fpu_addr   (fpu_addr),
    .fpu_ready  (fpu_ready),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_src     (wb_src),
    .xmm_busy   (xmm_busy),
    .overlap_err(overlap_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  // 0 none, 1 FPU, 2 MEM, 3 ALU
  function automatic int pick();
    if (reset) return 0;
    if (mem_valid && m_mem_wait >= LIMIT) return 2;
    if (alu_valid && m_alu_wait >= LIMIT) return 3;
    if (fpu_valid) return 1;
    if (mem_valid) return 2;
    if (alu_valid) return 3;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > LIMIT) ? LIMIT : v;
  endfunction

  task automatic model_clear();
    m_mem_wait = 0;
    m_alu_wait = 0;
    m_busy     = '0;
    m_ovf      = 1'b0;
  endtask

  // Compare every output against the model; called mid-cycle.
  task automatic cyc(input string tag);
    int g;
    logic [2:0]    e_rdy, e_src;
    logic [AW-1:0] e_addr;
    @(negedge clk);
    if (reset) model_clear();
    g = pick();
    e_rdy  = {g == 1, g == 2, g == 3};
    e_addr = (g == 1) ? fpu_addr : (g == 2) ? mem_addr : (g == 3) ? alu_addr : '0;
    case (g)
      1: e_src = 3'd6;
      2: e_src = 3'd4;
      3: e_src = (alu_kind == 2'd3) ? 3'd2 : {1'b0, alu_kind};
      default: e_src = 3'd0;
    endcase
    chk({tag, ".ready"}, 64'({fpu_ready, mem_ready, alu_ready}), 64'(e_rdy));
    chk({tag, ".wb_en"}, 64'(wb_en), 64'(g != 0));
    chk({tag, ".wb_addr"}, 64'(wb_addr), 64'(e_addr));
    chk({tag, ".wb_src"}, 64'(wb_src), 64'(e_src));
    chk({tag, ".busy"}, 64'(xmm_busy), 64'(m_busy));
    chk({tag, ".overlap"}, 64'(overlap_err), 64'(m_ovf));
  endtask

  // Advance through the rising edge, updating the model from the pre-edge inputs.
  task automatic adv();
    int g;
    logic [AW-1:0] ga;
    @(posedge clk);
    g = pick();
    ga = (g == 1) ? fpu_addr : (g == 2) ? mem_addr : alu_addr;
    if (reset) begin
      model_clear();
    end else begin
      if (issue_en && m_busy[issue_addr]) m_ovf = 1'b1;
      if (g != 0) m_busy[ga] = 1'b0;
      if (issue_en) m_busy[issue_addr] = 1'b1;
      m_mem_wait = (mem_valid && g != 2) ? sat(m_mem_wait + 1) : 0;
      m_alu_wait = (alu_valid && g != 3) ? sat(m_alu_wait + 1) : 0;
    end
    last_g = g;
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    fpu_valid = 1'b0;
    issue_en  = 1'b0;
  endtask

  initial begin
    model_clear();
    last_g = 0;
    reset = 1'b1;
    idle();
    alu_kind = 2'd1; alu_addr = 5'd3; mem_addr = 5'd4; fpu_addr = 5'd5; issue_addr = 5'd0;

    // Reset with every requester valid
    alu_valid = 1'b1; mem_valid = 1'b1; fpu_valid = 1'b1;
    cyc("rst");
    chk("rst.ready_none", 64'({fpu_ready, mem_ready, alu_ready}), 64'd0);
    chk("rst.wb_en", 64'(wb_en), 64'd0);
    adv();
    cyc("rst2");
    adv();
    reset = 1'b0;
    cyc("rst_rel");
    chk("rst_rel.fpu_ready", 64'(fpu_ready), 64'd1);
    chk("rst_rel.wb_src", 64'(wb_src), 64'd6);
    adv();
    idle();
    cyc("idle0");
    adv();

    // Priority order
    alu_valid = 1'b1; mem_valid = 1'b1; fpu_valid = 1'b1;
    cyc("prio_fpu");
    chk("prio_fpu.addr", 64'(wb_addr), 64'd5);
    adv();
    fpu_valid = 1'b0;
    cyc("prio_mem");
    chk("prio_mem.src", 64'(wb_src), 64'd4);
    chk("prio_mem.addr", 64'(wb_addr), 64'd4);
    adv();
    mem_valid = 1'b0;
    cyc("prio_alu");
    chk("prio_alu.src", 64'(wb_src), 64'd1);
    chk("prio_alu.addr", 64'(wb_addr), 64'd3);
    adv();
    idle();
    cyc("idle1");
    adv();

    // MEM starvation under continuous FPU
    fpu_valid = 1'b1; mem_valid = 1'b1; mem_addr = 5'd7;
    for (int i = 0; i < 9; i++) begin
      cyc("starve");
      chk("starve.mem_ready", 64'(mem_ready), 64'(i == 7));
      chk("starve.fpu_ready", 64'(fpu_ready), 64'(i != 7));
      adv();
    end
    idle();
    cyc("idle2");
    adv();

    // Dual boost: MEM first, then ALU ahead of FPU
    fpu_valid = 1'b1; mem_valid = 1'b1; alu_valid = 1'b1; alu_kind = 2'd0;
    alu_addr = 5'd2; mem_addr = 5'd6;
    for (int i = 0; i < 9; i++) begin
      cyc("dual");
      chk("dual.ready", 64'({fpu_ready, mem_ready, alu_ready}),
          64'((i < 7) ? 3'b100 : (i == 7) ? 3'b010 : 3'b001));
      adv();
      if (i == 7) mem_valid = 1'b0;
    end
    idle();
    cyc("idle3");
    adv();

    // Reset in the middle of a wait restarts aging from zero
    fpu_valid = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc("midwait");
      adv();
    end
    reset = 1'b1;
    cyc("midrst");
    adv();
    reset = 1'b0;
    for (int j = 0; j < 9; j++) begin
      cyc("rewait");
      chk("rewait.mem_ready", 64'(mem_ready), 64'(j == 7));
      adv();
    end
    idle();
    cyc("idle4");
    adv();

    // Scoreboard
    issue_en = 1'b1; issue_addr = 5'd9;
    cyc("sb_issue");
    adv();
    issue_en = 1'b0;
    cyc("sb_busy");
    chk("sb_busy.bit9", 64'(xmm_busy[9]), 64'd1);
    adv();
    mem_valid = 1'b1; mem_addr = 5'd9; issue_en = 1'b1; issue_addr = 5'd9;
    cyc("sb_both");
    chk("sb_both.mem_ready", 64'(mem_ready), 64'd1);
    adv();
    idle();
    cyc("sb_set_wins");
    chk("sb_set_wins.bit9", 64'(xmm_busy[9]), 64'd1);
    chk("sb_set_wins.overlap", 64'(overlap_err), 64'd1);
    adv();
    alu_valid = 1'b1; alu_kind = 2'd3; alu_addr = 5'd9;
    cyc("sb_wb");
    chk("sb_wb.src", 64'(wb_src), 64'd2);
    chk("sb_wb.addr", 64'(wb_addr), 64'd9);
    adv();
    idle();
    cyc("sb_clr");
    chk("sb_clr.bit9", 64'(xmm_busy[9]), 64'd0);
    adv();

    // Randomized traffic; requesters hold until granted
    for (int n = 0; n < 400; n++) begin
      if (!fpu_valid || last_g == 1) begin
        fpu_valid = ($urandom_range(0, 99) < 70);
        fpu_addr  = AW'($urandom);
      end
      if (!mem_valid || last_g == 2) begin
        mem_valid = ($urandom_range(0, 99) < 60);
        mem_addr  = AW'($urandom);
      end
      if (!alu_valid || last_g == 3) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_addr  = AW'($urandom);
        alu_kind  = 2'($urandom);
      end
      issue_en   = ($urandom_range(0, 3) == 0);
      issue_addr = AW'($urandom);
      cyc("rnd");
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
